// File: rtl/dispatch_queue_pkg.sv
// dispatch_queue shared definitions: widths, packet types, lane helpers.
// Imported by the queue, its interface and the bench.
package dispatch_queue_pkg;

    localparam int N_WAY    = 2;
    localparam int DQ_DEPTH = 8;
    localparam int XLEN     = 32;

    localparam int PTR_W = $clog2(DQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NUM_W = $clog2(N_WAY) + 1;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } DISPATCH_PACKET;

    typedef struct packed {
        DISPATCH_PACKET pkt;
        logic           branch;
    } DQ_ENTRY;

    // Number of consecutive ones starting at lane 0.
    function automatic logic [NUM_W-1:0] prefix_count(
        input logic [N_WAY-1:0] mask
    );
        logic [NUM_W-1:0] n;
        logic             run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < N_WAY; i++) begin
            run = run & mask[i];
            n   = n + NUM_W'(run);
        end
        return n;
    endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Fetch-side and ROB-side signals of the dispatch queue.
// master drives fetch/dispatched/flush; slave is the queue.
interface dispatch_queue_if;
    import dispatch_queue_pkg::*;

    DISPATCH_PACKET [N_WAY-1:0] fetch_packet;
    logic [N_WAY-1:0]           fetch_branch;
    logic [N_WAY-1:0]           fetch_valid;
    logic                       fetch_ready;
    DISPATCH_PACKET [N_WAY-1:0] dispatch_packet;
    logic [N_WAY-1:0]           branch_inst;
    logic [NUM_W-1:0]           dispatch_num;
    logic [N_WAY-1:0]           dispatched;
    logic                       branch_haz;
    logic [CNT_W-1:0]           dq_count;

    modport master (
        output fetch_packet, fetch_branch, fetch_valid,
        output dispatched, branch_haz,
        input  fetch_ready, dispatch_packet, branch_inst,
        input  dispatch_num, dq_count
    );

    modport slave (
        input  fetch_packet, fetch_branch, fetch_valid,
        input  dispatched, branch_haz,
        output fetch_ready, dispatch_packet, branch_inst,
        output dispatch_num, dq_count
    );

endinterface

// File: rtl/dispatch_queue.sv
// In-order circular dispatch queue between decode and rename/ROB.
// All outputs derive from registered state only.
module dispatch_queue
    import dispatch_queue_pkg::*;
(
    input logic             clock,
    input logic             reset,
    dispatch_queue_if.slave dq
);

    DQ_ENTRY          mem [DQ_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [N_WAY-1:0] lane_valid;
    logic [PTR_W-1:0] rd_idx [N_WAY];
    logic [NUM_W-1:0] push_n;
    logic [NUM_W-1:0] pop_n;

    always_comb begin
        for (int i = 0; i < N_WAY; i++) begin
            lane_valid[i] = CNT_W'(i) < count;
            rd_idx[i]     = head + PTR_W'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < N_WAY; i++) begin
            dq.dispatch_packet[i]       = mem[rd_idx[i]].pkt;
            dq.dispatch_packet[i].valid = lane_valid[i];
            dq.branch_inst[i]           = mem[rd_idx[i]].branch
                                          & lane_valid[i];
        end
    end

    assign dq.fetch_ready  = count <= CNT_W'(DQ_DEPTH - N_WAY);
    assign dq.dq_count     = count;
    assign dq.dispatch_num = (count >= CNT_W'(N_WAY))
                             ? NUM_W'(N_WAY) : NUM_W'(count);

    assign push_n = (dq.fetch_ready && !dq.branch_haz)
                    ? prefix_count(dq.fetch_valid) : '0;
    assign pop_n  = dq.branch_haz
                    ? '0 : prefix_count(dq.dispatched & lane_valid);

    // Storage is not reset; count alone decides what is live.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_WAY; i++) begin
                if (NUM_W'(i) < push_n) begin
                    mem[tail + PTR_W'(i)] <= '{
                        pkt:    dq.fetch_packet[i],
                        branch: dq.fetch_branch[i]
                    };
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || dq.branch_haz) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_n);
            tail  <= tail + PTR_W'(push_n);
            count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    // ROB-side protocol: dispatched must be a prefix of valid lanes.
    always_ff @(posedge clock) begin
        if (!reset && !dq.branch_haz) begin
            assert ((dq.dispatched & ~lane_valid) == '0)
                else $error("dispatched on invalid lane %b", dq.dispatched);
            assert (NUM_W'($countones(dq.dispatched))
                    == prefix_count(dq.dispatched))
                else $error("dispatched not a prefix %b", dq.dispatched);
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue with hand-computed expectations.
// Covers push/pop, full, wrap, flush and reset.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    dispatch_queue_if bus ();

    dispatch_queue dut (
        .clock (clock),
        .reset (reset),
        .dq    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag,
                            input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0]  fv,
                         input logic [1:0]  br,
                         input logic [31:0] pc0,
                         input logic [31:0] pc1,
                         input logic [1:0]  disp,
                         input logic        haz);
        bus.fetch_valid     = fv;
        bus.fetch_branch    = br;
        bus.fetch_packet[0] = '{valid: fv[0], pc: pc0, inst: 32'h13};
        bus.fetch_packet[1] = '{valid: fv[1], pc: pc1, inst: 32'h13};
        bus.dispatched      = disp;
        bus.branch_haz      = haz;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag,
                               input int cnt,
                               input int num,
                               input logic [1:0] vld,
                               input logic rdy);
        check_eq({tag, ".count"}, 64'(bus.dq_count), 64'(cnt));
        check_eq({tag, ".num"}, 64'(bus.dispatch_num), 64'(num));
        check_eq({tag, ".v0"}, 64'(bus.dispatch_packet[0].valid),
                 64'(vld[0]));
        check_eq({tag, ".v1"}, 64'(bus.dispatch_packet[1].valid),
                 64'(vld[1]));
        check_eq({tag, ".ready"}, 64'(bus.fetch_ready), 64'(rdy));
    endtask

    task automatic check_pcs(input string tag,
                             input logic [31:0] pc0,
                             input logic [31:0] pc1);
        check_eq({tag, ".pc0"}, 64'(bus.dispatch_packet[0].pc), 64'(pc0));
        check_eq({tag, ".pc1"}, 64'(bus.dispatch_packet[1].pc), 64'(pc1));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        check_state("rst", 0, 0, 2'b00, 1'b1);
        check_eq("rst.br", 64'(bus.branch_inst), 64'h0);

        // basic push, lane 1 is a branch
        drive(2'b11, 2'b10, 32'h0, 32'h4, 2'b00, 1'b0);
        step();
        check_state("push", 2, 2, 2'b11, 1'b1);
        check_pcs("push", 32'h0, 32'h4);
        check_eq("push.br", 64'(bus.branch_inst), 64'h2);
        drive(2'b01, 2'b00, 32'h8, 32'h0, 2'b00, 1'b0);
        step();
        check_eq("push3.count", 64'(bus.dq_count), 64'd3);

        // single-lane pop shifts the window
        drive(2'b00, 2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
        step();
        check_state("pop1", 2, 2, 2'b11, 1'b1);
        check_pcs("pop1", 32'h4, 32'h8);
        check_eq("pop1.br", 64'(bus.branch_inst), 64'h1);
        drive(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step();
        check_state("drain", 0, 0, 2'b00, 1'b1);
        check_eq("drain.br", 64'(bus.branch_inst), 64'h0);

        // fill from a clean reset so wrap lands on indices 0/1
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        for (int g = 0; g < 4; g++) begin
            drive(2'b11, 2'b00, 32'h10 + 32'(8 * g),
                  32'h14 + 32'(8 * g), 2'b00, 1'b0);
            step();
            check_eq("fill.count", 64'(bus.dq_count), 64'(2 * g + 2));
        end
        check_eq("full.ready", 64'(bus.fetch_ready), 64'h0);
        drive(2'b11, 2'b00, 32'h30, 32'h34, 2'b00, 1'b0);
        step();
        check_state("full.hold", 8, 2, 2'b11, 1'b0);
        check_pcs("full.hold", 32'h10, 32'h14);
        drive(2'b11, 2'b00, 32'h30, 32'h34, 2'b11, 1'b0);
        step();
        check_state("full.pop", 6, 2, 2'b11, 1'b1);
        check_pcs("full.pop", 32'h18, 32'h1c);
        drive(2'b11, 2'b00, 32'h30, 32'h34, 2'b00, 1'b0);
        step();
        check_eq("refill.count", 64'(bus.dq_count), 64'd8);
        for (int g = 0; g < 3; g++) begin
            drive(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
            step();
        end
        check_state("wrap", 2, 2, 2'b11, 1'b1);
        check_pcs("wrap", 32'h30, 32'h34);

        // occupancy 5 with simultaneous push/pop, tail 7 -> 1
        drive(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step();
        drive(2'b11, 2'b00, 32'h40, 32'h44, 2'b00, 1'b0);
        step();
        drive(2'b11, 2'b00, 32'h48, 32'h4c, 2'b00, 1'b0);
        step();
        drive(2'b01, 2'b00, 32'h50, 32'h0, 2'b00, 1'b0);
        step();
        check_eq("occ5.count", 64'(bus.dq_count), 64'd5);
        drive(2'b11, 2'b00, 32'h54, 32'h58, 2'b11, 1'b0);
        step();
        check_state("pushpop", 5, 2, 2'b11, 1'b1);
        check_pcs("pushpop", 32'h48, 32'h4c);
        drive(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step();
        check_pcs("cross", 32'h50, 32'h54);
        step();
        check_state("tail1", 1, 1, 2'b01, 1'b1);
        check_eq("tail1.pc0", 64'(bus.dispatch_packet[0].pc), 64'h58);

        // flush at count 6 drops same-cycle push and pop
        drive(2'b11, 2'b00, 32'h60, 32'h64, 2'b00, 1'b0);
        step();
        drive(2'b11, 2'b00, 32'h68, 32'h6c, 2'b00, 1'b0);
        step();
        drive(2'b01, 2'b01, 32'h70, 32'h0, 2'b00, 1'b0);
        step();
        check_state("pre.haz", 6, 2, 2'b11, 1'b1);
        drive(2'b11, 2'b11, 32'h74, 32'h78, 2'b11, 1'b1);
        step();
        check_state("haz", 0, 0, 2'b00, 1'b1);
        check_eq("haz.br", 64'(bus.branch_inst), 64'h0);
        drive(2'b01, 2'b00, 32'h80, 32'h0, 2'b00, 1'b0);
        step();
        check_state("post.haz", 1, 1, 2'b01, 1'b1);
        check_eq("post.haz.pc0", 64'(bus.dispatch_packet[0].pc), 64'h80);

        // reset wins over a pending push
        drive(2'b11, 2'b00, 32'h84, 32'h88, 2'b00, 1'b0);
        step();
        drive(2'b01, 2'b00, 32'h8c, 32'h0, 2'b00, 1'b0);
        step();
        check_eq("pre.rst.count", 64'(bus.dq_count), 64'd4);
        drive(2'b11, 2'b00, 32'h90, 32'h94, 2'b00, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        check_state("rst2", 0, 0, 2'b00, 1'b1);
        step();
        check_state("rst2.idle", 0, 0, 2'b00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
